nal_start_code_scanner: RTL and testbench
=========================================

// Module: nal_start_code_scanner
// PURPOSE
// - Byte-stream front end of the NAL Parser; feeds the chunking bitstream reader.
// - Finds 0x000001 start codes in the raw H.265 byte stream and drops start codes and leading/trailing zero runs.
// - Removes emulation-prevention bytes (00 00 03 -> 00 00) and decodes the 2-byte NAL header.
// - Forwards the header plus unescaped payload bytes, one per cycle, on an out_valid strobe.
// PARAMETERS
// - ZERO_CNT_W  4  width of pending-zero counter; max held zero run = 2**ZERO_CNT_W-1
// PORTS
// clk              in   1  clock, all logic on posedge
// reset_n          in   1  asynchronous active-low reset
// in_data          in   8  raw stream byte
// in_valid         in   1  in_data valid; byte accepted when in_valid && in_ready
// in_ready         out  1  scanner can accept a byte this cycle
// out_data         out  8  unescaped NAL byte (header + payload)
// out_valid        out  1  out_data valid, single-cycle strobe per byte, no backpressure
// nal_start        out  1  pulse with first header byte on out_valid
// nal_end          out  1  pulse when a start code terminates a NAL in progress
// nal_unit_type    out  6  header byte0[6:1], held until next header
// nuh_layer_id     out  6  {byte0[0], byte1[7:3]}, held
// nuh_temporal_id  out  3  byte1[2:0]-1, held
// header_valid     out  1  pulse with second header byte on out_valid
// hdr_err          out  1  pulse with header_valid if forbidden bit=1 or tid_plus1=0
// epb_removed      out  1  pulse when an 0x03 emulation-prevention byte is dropped
// zero_overflow    out  1  pulse when a zero run exceeds counter capacity
// BEHAVIOUR
// - Reset: state=SEARCH, zc=0, pz=0; in_ready=1; all outputs and held fields 0.
// - zc = consecutive-zero count on accepted bytes (saturates at 3); pz = zeros held back in PAYLOAD.
// - Start code: accepted byte 0x01 with zc>=2 in any state -> state HDR0, zc=0, pz=0 (held zeros discarded).
//   If state was HDR0/HDR1/PAYLOAD/FLUSH-from-PAYLOAD, nal_end pulses next cycle.
// - SEARCH: all bytes discarded, only zc tracked.
// - HDR0: byte forwarded literally (no zero holding), fields latched, nal_start with it; -> HDR1.
// - HDR1: byte forwarded literally; header_valid/hdr_err with it; -> PAYLOAD; zc=0.
// - PAYLOAD, accepted byte b:
//   - b==0x00: pz++ (no output); if pz at max, pz holds and zero_overflow pulses (zero dropped).
//   - b==0x03 && pz>=2: emit pz zeros, drop b, epb_removed pulses; zc=0.
//   - b==0x01 && pz>=2: start code (above).
//   - other b: emit pz zeros then b.
// - Emitting with pz>0: capture b (or none for EPB), state FLUSH, in_ready=0;
//   one zero per cycle on out_valid, then captured byte, then in_ready=1 and PAYLOAD.
// - FLUSH duration = pz (+1 if byte captured) cycles; no input accepted.
// - Latency: accepted byte appears on out_data/out_valid the next cycle when pz==0.
// - in_ready is registered; in_ready=0 only in FLUSH.
// - Zeros pending at stream end are never emitted (treated as trailing_zero_8bits).
// - Header fields change only on header_valid/nal_start cycles.
// - reset_n low mid-FLUSH aborts flush; captured byte lost; outputs 0 asynchronously.
// TESTING
// 1. 00 00 01 40 01 AA BB -> out 40,01,AA,BB; nal_start@40; header_valid@01; type=32, layer=0, tid=0.
// 2. 00 00 01 26 01 11 00 00 03 01 22 -> out 26,01,11,00,00,01,22; one epb_removed; in_ready low 2 cycles.
// 3. NAL payload 55 00 00 00 00 01 02 01 -> 55 emitted, zeros dropped, nal_end pulse, new header 02,01 (type=1).
// 4. Leading garbage FF 12 00 00 00 01 40 01 -> nothing before 40; nal_start with 40.
// 5. 00 00 01 80 00 -> forwarded 80,00; hdr_err pulses with header_valid.
// 6. 20 zeros in PAYLOAD then 7F (ZERO_CNT_W=4) -> zero_overflow 5x, 15 zeros then 7F; reset_n low mid-flush -> out_valid=0 at once.

Source files
------------

// File: rtl/nal_start_code_scanner.sv
// Byte-stream front end of the NAL parser: finds 00 00 01 start codes, strips zero runs
// and emulation-prevention bytes, decodes the 2-byte NAL header and forwards the NAL bytes.
module nal_start_code_scanner #(
  parameter int ZERO_CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       nal_start,
  output logic       nal_end,
  output logic [5:0] nal_unit_type,
  output logic [5:0] nuh_layer_id,
  output logic [2:0] nuh_temporal_id,
  output logic       header_valid,
  output logic       hdr_err,
  output logic       epb_removed,
  output logic       zero_overflow
);

  typedef enum logic [2:0] {SEARCH, HDR0, HDR1, PAYLOAD, FLUSH} state_e;

  localparam logic [ZERO_CNT_W-1:0] PZ_MAX = '1;
  localparam logic [ZERO_CNT_W-1:0] PZ_ONE = ZERO_CNT_W'(1);
  localparam logic [ZERO_CNT_W-1:0] PZ_TWO = ZERO_CNT_W'(2);

  state_e                state_q;
  logic [1:0]            zc_q;
  logic [1:0]            zc_d;
  logic [ZERO_CNT_W-1:0] pz_q;
  logic [7:0]            cap_q;
  logic                  cap_valid_q;
  logic                  forbidden_q;
  logic                  in_ready_q;
  logic [7:0]            out_data_q;
  logic                  out_valid_q;
  logic                  nal_start_q;
  logic                  nal_end_q;
  logic [5:0]            type_q;
  logic [5:0]            layer_q;
  logic [2:0]            tid_q;
  logic                  header_valid_q;
  logic                  hdr_err_q;
  logic                  epb_removed_q;
  logic                  zero_overflow_q;

  logic accept;
  logic is_zero;
  logic is_one;
  logic is_epb;
  logic start_code;

  assign accept  = in_valid && in_ready_q;
  assign is_zero = (in_data == 8'h00);
  assign is_one  = (in_data == 8'h01);
  assign is_epb  = (in_data == 8'h03);
  assign zc_d    = is_zero ? ((zc_q == 2'd3) ? 2'd3 : zc_q + 2'd1) : 2'd0;

  // Inside a payload the held-zero count is the authoritative zero run.
  assign start_code = accept && is_one &&
                      ((state_q == PAYLOAD) ? (pz_q >= PZ_TWO) : zc_q[1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= SEARCH;
      zc_q            <= 2'd0;
      pz_q            <= '0;
      cap_q           <= 8'h00;
      cap_valid_q     <= 1'b0;
      forbidden_q     <= 1'b0;
      in_ready_q      <= 1'b1;
      out_data_q      <= 8'h00;
      out_valid_q     <= 1'b0;
      nal_start_q     <= 1'b0;
      nal_end_q       <= 1'b0;
      type_q          <= 6'd0;
      layer_q         <= 6'd0;
      tid_q           <= 3'd0;
      header_valid_q  <= 1'b0;
      hdr_err_q       <= 1'b0;
      epb_removed_q   <= 1'b0;
      zero_overflow_q <= 1'b0;
    end else begin
      // NOTE: strobes default low here and are raised below, so each is a one-cycle pulse.
      out_valid_q     <= 1'b0;
      nal_start_q     <= 1'b0;
      nal_end_q       <= 1'b0;
      header_valid_q  <= 1'b0;
      hdr_err_q       <= 1'b0;
      epb_removed_q   <= 1'b0;
      zero_overflow_q <= 1'b0;

      if (state_q == FLUSH) begin
        if (pz_q != '0) begin
          out_valid_q <= 1'b1;
          out_data_q  <= 8'h00;
          pz_q        <= pz_q - PZ_ONE;
        end else if (cap_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= cap_q;
          cap_valid_q <= 1'b0;
        end else begin
          state_q    <= PAYLOAD;
          in_ready_q <= 1'b1;
        end
      end else if (accept) begin
        zc_q <= zc_d;
        if (start_code) begin
          state_q   <= HDR0;
          zc_q      <= 2'd0;
          pz_q      <= '0;
          nal_end_q <= (state_q != SEARCH);
        end else begin
          case (state_q)
            HDR0: begin
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
              nal_start_q <= 1'b1;
              forbidden_q <= in_data[7];
              type_q      <= in_data[6:1];
              layer_q[5]  <= in_data[0];
              state_q     <= HDR1;
            end
            HDR1: begin
              out_valid_q    <= 1'b1;
              out_data_q     <= in_data;
              header_valid_q <= 1'b1;
              hdr_err_q      <= forbidden_q || (in_data[2:0] == 3'd0);
              layer_q[4:0]   <= in_data[7:3];
              tid_q          <= in_data[2:0] - 3'd1;
              zc_q           <= 2'd0;
              state_q        <= PAYLOAD;
            end
            PAYLOAD: begin
              if (is_zero) begin
                if (pz_q == PZ_MAX) zero_overflow_q <= 1'b1;
                else                pz_q            <= pz_q + PZ_ONE;
              end else if (pz_q != '0) begin
                // First held zero goes out now; FLUSH drains the rest and the captured byte.
                out_valid_q   <= 1'b1;
                out_data_q    <= 8'h00;
                pz_q          <= pz_q - PZ_ONE;
                cap_q         <= in_data;
                cap_valid_q   <= !(is_epb && pz_q >= PZ_TWO);
                epb_removed_q <= is_epb && pz_q >= PZ_TWO;
                if (is_epb && pz_q >= PZ_TWO) zc_q <= 2'd0;
                state_q       <= FLUSH;
                in_ready_q    <= 1'b0;
              end else begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign in_ready        = in_ready_q;
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign nal_start       = nal_start_q;
  assign nal_end         = nal_end_q;
  assign nal_unit_type   = type_q;
  assign nuh_layer_id    = layer_q;
  assign nuh_temporal_id = tid_q;
  assign header_valid    = header_valid_q;
  assign hdr_err         = hdr_err_q;
  assign epb_removed     = epb_removed_q;
  assign zero_overflow   = zero_overflow_q;

endmodule

// File: tb/tb_nal_start_code_scanner.sv
// Directed bench for nal_start_code_scanner: byte streams in, captured output bytes and
// strobe counts compared against hand-computed expectations.
module tb_nal_start_code_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       nal_start;
  logic       nal_end;
  logic [5:0] nal_unit_type;
  logic [5:0] nuh_layer_id;
  logic [2:0] nuh_temporal_id;
  logic       header_valid;
  logic       hdr_err;
  logic       epb_removed;
  logic       zero_overflow;

  nal_start_code_scanner #(.ZERO_CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .nal_start(nal_start), .nal_end(nal_end),
    .nal_unit_type(nal_unit_type), .nuh_layer_id(nuh_layer_id),
    .nuh_temporal_id(nuh_temporal_id), .header_valid(header_valid),
    .hdr_err(hdr_err), .epb_removed(epb_removed), .zero_overflow(zero_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];
  int n_start, n_end, n_hv, n_err, n_epb, n_ovf, n_ready_low, end_at_out;
  logic [7:0] start_byte, hv_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) out_q.push_back(out_data);
      if (nal_start) begin n_start++; start_byte = out_data; end
      if (nal_end) begin n_end++; end_at_out = out_q.size(); end
      if (header_valid) begin n_hv++; hv_byte = out_data; end
      if (hdr_err) n_err++;
      if (epb_removed) n_epb++;
      if (zero_overflow) n_ovf++;
      if (!in_ready) n_ready_low++;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    out_q.delete();
    n_start = 0; n_end = 0; n_hv = 0; n_err = 0; n_epb = 0; n_ovf = 0;
    n_ready_low = 0; end_at_out = -1; start_byte = 8'h00; hv_byte = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_stream();
    foreach (stim_q[i]) send(stim_q[i]);
    repeat (24) @(negedge clk);
  endtask

  task automatic expect_bytes(input string tag);
    check({tag, "_len"}, out_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < out_q.size()) check($sformatf("%s_b%0d", tag, i), out_q[i], exp_q[i]);
  endtask

  initial begin
    do_reset();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_type", {26'd0, nal_unit_type}, 32'd0);
    check("rst_tid", {29'd0, nuh_temporal_id}, 32'd0);

    // 1: basic NAL
    stim_q = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'hAA, 8'hBB};
    run_stream();
    exp_q = '{8'h40, 8'h01, 8'hAA, 8'hBB};
    expect_bytes("t1_out");
    check("t1_nal_start", n_start, 1);
    check("t1_start_byte", start_byte, 8'h40);
    check("t1_hv_byte", hv_byte, 8'h01);
    check("t1_type", {26'd0, nal_unit_type}, 32);
    check("t1_layer", {26'd0, nuh_layer_id}, 0);
    check("t1_tid", {29'd0, nuh_temporal_id}, 0);
    check("t1_hdr_err", n_err, 0);
    check("t1_nal_end", n_end, 0);

    // 2: emulation-prevention byte removal
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h01, 8'h26, 8'h01, 8'h11, 8'h00, 8'h00, 8'h03, 8'h01, 8'h22};
    run_stream();
    exp_q = '{8'h26, 8'h01, 8'h11, 8'h00, 8'h00, 8'h01, 8'h22};
    expect_bytes("t2_out");
    check("t2_epb", n_epb, 1);
    check("t2_ready_low", n_ready_low, 2);
    check("t2_type", {26'd0, nal_unit_type}, 19);
    check("t2_nal_end", n_end, 0);

    // 3: start code inside payload ends the NAL, trailing zeros dropped
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h02, 8'h01};
    run_stream();
    exp_q = '{8'h40, 8'h01, 8'h55, 8'h02, 8'h01};
    expect_bytes("t3_out");
    check("t3_nal_end", n_end, 1);
    check("t3_end_pos", end_at_out, 3);
    check("t3_nal_start", n_start, 2);
    check("t3_start_byte", start_byte, 8'h02);
    check("t3_type", {26'd0, nal_unit_type}, 1);
    check("t3_tid", {29'd0, nuh_temporal_id}, 0);

    // 4: leading garbage before the first start code
    do_reset();
    stim_q = '{8'hFF, 8'h12, 8'h00, 8'h00, 8'h00, 8'h01, 8'h40, 8'h01};
    run_stream();
    exp_q = '{8'h40, 8'h01};
    expect_bytes("t4_out");
    check("t4_start_byte", start_byte, 8'h40);
    check("t4_nal_start", n_start, 1);

    // 5: forbidden bit set and tid_plus1 = 0
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h01, 8'h80, 8'h00};
    run_stream();
    exp_q = '{8'h80, 8'h00};
    expect_bytes("t5_out");
    check("t5_hv", n_hv, 1);
    check("t5_hdr_err", n_err, 1);
    check("t5_type", {26'd0, nal_unit_type}, 0);
    check("t5_tid", {29'd0, nuh_temporal_id}, 7);

    // 6: zero-run overflow, then long flush
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01};
    for (int i = 0; i < 20; i++) stim_q.push_back(8'h00);
    stim_q.push_back(8'h7F);
    run_stream();
    exp_q = '{8'h40, 8'h01};
    for (int i = 0; i < 15; i++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h7F);
    expect_bytes("t6_out");
    check("t6_overflow", n_ovf, 5);
    check("t6_ready_low", n_ready_low, 16);

    // 6b: reset asserted in the middle of a flush
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F};
    foreach (stim_q[i]) send(stim_q[i]);
    check("t6b_flush_valid", {31'd0, out_valid}, 32'd1);
    check("t6b_flush_ready", {31'd0, in_ready}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("t6b_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6b_rst_ready", {31'd0, in_ready}, 32'd1);
    check("t6b_rst_type", {26'd0, nal_unit_type}, 32'd0);
    do_reset();
    repeat (10) @(negedge clk);
    check("t6b_no_output", out_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
